// File: rtl/z_writeback_if.sv
// ALU-result and shared-bus signals for the z_writeback stage; slave is the stage, master drives it.
// Z_FLAGS_EN adds the z_zero/z_neg flag outputs.
interface z_writeback_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 12
);
  logic [WIDTH-1:0]  ZHI;
  logic [WIDTH-1:0]  ZLO;
  logic [CTRL_W-1:0] ctrl;
  logic              z_valid;
  logic              z_ready;
  logic              bus_req;
  logic              bus_grant;
  logic [WIDTH-1:0]  bus_data;
  logic              rz_wr;
  logic              lo_wr;
  logic              hi_wr;
  logic              wb_done;
  logic              illegal_op;
`ifdef Z_FLAGS_EN
  logic              z_zero;
  logic              z_neg;

  modport slave (
    input  ZHI, ZLO, ctrl, z_valid, bus_grant,
    output z_ready, bus_req, bus_data, rz_wr, lo_wr, hi_wr, wb_done, illegal_op,
    output z_zero, z_neg
  );

  modport master (
    output ZHI, ZLO, ctrl, z_valid, bus_grant,
    input  z_ready, bus_req, bus_data, rz_wr, lo_wr, hi_wr, wb_done, illegal_op,
    input  z_zero, z_neg
  );
`else
  modport slave (
    input  ZHI, ZLO, ctrl, z_valid, bus_grant,
    output z_ready, bus_req, bus_data, rz_wr, lo_wr, hi_wr, wb_done, illegal_op
  );

  modport master (
    output ZHI, ZLO, ctrl, z_valid, bus_grant,
    input  z_ready, bus_req, bus_data, rz_wr, lo_wr, hi_wr, wb_done, illegal_op
  );
`endif
endinterface

// File: rtl/z_writeback.sv
// Purpose: ALU write-back; drains ZHI/ZLO onto the shared bus as Rz or LO+HI beats (Z_FLAGS_EN adds z_zero/z_neg).
// Latency: first strobe 1 cycle after capture with grant held; wb_done registered one cycle after final beat.
// Backpressure: z_ready only in IDLE or on the final granted beat; each beat holds bus_data until granted.
module z_writeback #(
  parameter int WIDTH   = 32,
  parameter int CTRL_W  = 12,
  parameter int MUL_BIT = 8,
  parameter int DIV_BIT = 9
) (
  input  logic          clk,
  input  logic          clr,
  z_writeback_if.slave  zif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_Z  = 2'd1,
    WR_LO = 2'd2,
    WR_HI = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } zpair_t;

  state_t            state;
  state_t            state_nxt;
  zpair_t            zpair;
  logic [CTRL_W-1:0] ctrl;
  logic              one_hot;
  logic              two_beat;
  logic              capture;
  logic              z_ready;
  logic              final_beat;
  logic              bus_req;
  logic [WIDTH-1:0]  bus_data;
  logic              rz_wr;
  logic              lo_wr;
  logic              hi_wr;
  logic              wb_done_q;
  logic              illegal_q;

  assign ctrl     = zif.ctrl;
  assign one_hot  = (ctrl != '0) && ((ctrl & (ctrl - CTRL_W'(1))) == '0);
  // An illegal ctrl still drains: two beats whenever a mul/div bit is present.
  assign two_beat = ctrl[MUL_BIT] | ctrl[DIV_BIT];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bus_req    = 1'b0;
    bus_data   = '0;
    rz_wr      = 1'b0;
    lo_wr      = 1'b0;
    hi_wr      = 1'b0;
    final_beat = 1'b0;
    unique case (state)
      IDLE: begin
      end
      WR_Z: begin
        bus_req  = 1'b1;
        bus_data = zpair.lo;
        if (zif.bus_grant) begin
          rz_wr      = 1'b1;
          final_beat = 1'b1;
          state_nxt  = IDLE;
        end
      end
      WR_LO: begin
        bus_req  = 1'b1;
        bus_data = zpair.lo;
        if (zif.bus_grant) begin
          lo_wr     = 1'b1;
          state_nxt = WR_HI;
        end
      end
      WR_HI: begin
        bus_req  = 1'b1;
        bus_data = zpair.hi;
        if (zif.bus_grant) begin
          hi_wr      = 1'b1;
          final_beat = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Accepting on the final beat lets the next result follow with no bubble.
    z_ready = (state == IDLE) | final_beat;
    capture = zif.z_valid & z_ready;
    if (capture) begin
      state_nxt = two_beat ? WR_LO : WR_Z;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      zpair     <= '0;
      wb_done_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      wb_done_q <= final_beat;
      if (capture) begin
        zpair.hi <= zif.ZHI;
        zpair.lo <= zif.ZLO;
        if (!one_hot) begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

`ifdef Z_FLAGS_EN
  logic z_zero_q;
  logic z_neg_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      z_zero_q <= 1'b0;
      z_neg_q  <= 1'b0;
    end else if (capture) begin
      z_zero_q <= (zif.ZLO == '0);
      z_neg_q  <= zif.ZLO[WIDTH-1];
    end
  end

  assign zif.z_zero = z_zero_q;
  assign zif.z_neg  = z_neg_q;
`endif

  assign zif.z_ready    = z_ready;
  assign zif.bus_req    = bus_req;
  assign zif.bus_data   = bus_data;
  assign zif.rz_wr      = rz_wr;
  assign zif.lo_wr      = lo_wr;
  assign zif.hi_wr      = hi_wr;
  assign zif.wb_done    = wb_done_q;
  assign zif.illegal_op = illegal_q;

endmodule

// File: tb/tb_z_writeback.sv
// Bench for z_writeback: directed table of single ops, hand-written stall/reset/back-to-back
// sequences, then randomized traffic checked against a queue-of-beats reference model.
module tb_z_writeback;
  localparam int WIDTH  = 32;
  localparam int CTRL_W = 12;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  z_writeback_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) zif ();

  z_writeback #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .MUL_BIT(8), .DIV_BIT(9)) dut (
    .clk (clk),
    .clr (clr),
    .zif (zif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic strobes(input string name, input logic rz, input logic lo, input logic hi);
    chk({name, ".rz_wr"}, 32'(zif.rz_wr), 32'(rz));
    chk({name, ".lo_wr"}, 32'(zif.lo_wr), 32'(lo));
    chk({name, ".hi_wr"}, 32'(zif.hi_wr), 32'(hi));
  endtask

  task automatic drive_idle;
    zif.z_valid   = 1'b0;
    zif.ctrl      = '0;
    zif.ZHI       = '0;
    zif.ZLO       = '0;
    zif.bus_grant = 1'b0;
  endtask

  task automatic do_reset;
    drive_idle();
    clr = 1'b0;
    tick();
    tick();
    clr = 1'b1;
  endtask

  task automatic drive_op(input logic [11:0] c, input logic [31:0] hi, input logic [31:0] lo);
    zif.z_valid = 1'b1;
    zif.ctrl    = c;
    zif.ZHI     = hi;
    zif.ZLO     = lo;
  endtask

  typedef struct {
    logic [11:0] ctrl;
    logic [31:0] zhi;
    logic [31:0] zlo;
    logic        two;
    logic        ill;
  } vec_t;

  typedef struct {
    int          kind;  // 0 = Rz, 1 = LO, 2 = HI
    logic [31:0] data;
  } beat_t;

  vec_t  vecs[7];
  beat_t q[$];

  initial begin
    vecs[0] = '{12'h001, 32'hAAAA_0000, 32'h0000_0005, 1'b0, 1'b0};
    vecs[1] = '{12'h100, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[2] = '{12'h200, 32'h0000_0003, 32'h0000_0007, 1'b1, 1'b0};
    vecs[3] = '{12'h800, 32'h1234_5678, 32'h8000_0000, 1'b0, 1'b0};
    vecs[4] = '{12'h003, 32'h0000_0009, 32'h0000_0000, 1'b0, 1'b1};
    vecs[5] = '{12'h000, 32'h0000_0004, 32'h0000_0011, 1'b0, 1'b1};
    vecs[6] = '{12'h101, 32'hCAFE_0001, 32'hBEEF_0002, 1'b1, 1'b1};

    // Reset state
    do_reset();
    settle();
    chk("rst.z_ready", 32'(zif.z_ready), 32'd1);
    chk("rst.bus_req", 32'(zif.bus_req), 32'd0);
    chk("rst.bus_data", zif.bus_data, 32'd0);
    chk("rst.wb_done", 32'(zif.wb_done), 32'd0);
    chk("rst.illegal", 32'(zif.illegal_op), 32'd0);
    strobes("rst", 1'b0, 1'b0, 1'b0);

    // Grant with no request does nothing
    zif.bus_grant = 1'b1;
    settle();
    strobes("idle_grant", 1'b0, 1'b0, 1'b0);
    tick();
    chk("idle_grant.wb_done", 32'(zif.wb_done), 32'd0);

    // Reset mid-WR_LO aborts the pending beat
    zif.bus_grant = 1'b0;
    drive_op(12'h200, 32'd3, 32'd7);
    tick();
    drive_idle();
    settle();
    chk("rstmid.bus_req_before", 32'(zif.bus_req), 32'd1);
    zif.bus_grant = 1'b1;
    clr = 1'b0;
    settle();
    chk("rstmid.bus_req", 32'(zif.bus_req), 32'd0);
    strobes("rstmid", 1'b0, 1'b0, 1'b0);
    tick();
    clr = 1'b1;
    settle();
    chk("rstmid.z_ready", 32'(zif.z_ready), 32'd1);
    chk("rstmid.bus_data", zif.bus_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      strobes("rstmid.after", 1'b0, 1'b0, 1'b0);
      tick();
      chk("rstmid.wb_done", 32'(zif.wb_done), 32'd0);
    end

    // Table of single ops, grant held high
    zif.bus_grant = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_op(vecs[i].ctrl, vecs[i].zhi, vecs[i].zlo);
      settle();
      chk("tbl.z_ready", 32'(zif.z_ready), 32'd1);
      tick();
      drive_idle();
      zif.bus_grant = 1'b1;
      settle();
      chk("tbl.illegal", 32'(zif.illegal_op), 32'(vecs[i].ill));
`ifdef Z_FLAGS_EN
      chk("tbl.z_zero", 32'(zif.z_zero), 32'(vecs[i].zlo == 32'd0));
      chk("tbl.z_neg", 32'(zif.z_neg), 32'(vecs[i].zlo[31]));
`endif
      chk("tbl.beat1_data", zif.bus_data, vecs[i].zlo);
      if (vecs[i].two) begin
        strobes("tbl.beat1_lo", 1'b0, 1'b1, 1'b0);
        chk("tbl.z_ready_lo", 32'(zif.z_ready), 32'd0);
        tick();
        settle();
        chk("tbl.wb_done_mid", 32'(zif.wb_done), 32'd0);
        chk("tbl.beat2_data", zif.bus_data, vecs[i].zhi);
        strobes("tbl.beat2_hi", 1'b0, 1'b0, 1'b1);
      end else begin
        strobes("tbl.beat1_rz", 1'b1, 1'b0, 1'b0);
      end
      tick();
      settle();
      chk("tbl.wb_done", 32'(zif.wb_done), 32'd1);
      chk("tbl.bus_req_end", 32'(zif.bus_req), 32'd0);
      tick();
      chk("tbl.wb_done_pulse", 32'(zif.wb_done), 32'd0);
    end
    chk("tbl.illegal_sticky", 32'(zif.illegal_op), 32'd1);

    // Stall: div held off by grant=0; a new z_valid must not be taken
    do_reset();
    drive_op(12'h200, 32'd3, 32'd7);
    tick();
    drive_op(12'h001, 32'd0, 32'd9);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("stall.bus_data", zif.bus_data, 32'd7);
      chk("stall.z_ready", 32'(zif.z_ready), 32'd0);
      chk("stall.bus_req", 32'(zif.bus_req), 32'd1);
      strobes("stall", 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive_idle();
    zif.bus_grant = 1'b1;
    settle();
    chk("stall.lo_data", zif.bus_data, 32'd7);
    strobes("stall.lo", 1'b0, 1'b1, 1'b0);
    tick();
    settle();
    chk("stall.hi_data", zif.bus_data, 32'd3);
    strobes("stall.hi", 1'b0, 1'b0, 1'b1);
    tick();
    chk("stall.wb_done", 32'(zif.wb_done), 32'd1);

    // Back-to-back single-beat ops with no bubble
    do_reset();
    zif.bus_grant = 1'b1;
    drive_op(12'h001, 32'd0, 32'd1);
    tick();
    drive_op(12'h002, 32'd0, 32'd2);
    settle();
    chk("b2b.z_ready", 32'(zif.z_ready), 32'd1);
    chk("b2b.data1", zif.bus_data, 32'd1);
    strobes("b2b.first", 1'b1, 1'b0, 1'b0);
    tick();
    zif.z_valid = 1'b0;
    settle();
    chk("b2b.data2", zif.bus_data, 32'd2);
    strobes("b2b.second", 1'b1, 1'b0, 1'b0);
    chk("b2b.wb_done1", 32'(zif.wb_done), 32'd1);
    tick();
    chk("b2b.wb_done2", 32'(zif.wb_done), 32'd1);
    chk("b2b.idle", 32'(zif.bus_req), 32'd0);

    // Randomized traffic against a queue-of-beats model
    do_reset();
    begin
      logic        exp_done = 1'b0;
      logic        exp_ill  = 1'b0;
      logic        exp_zero = 1'b0;
      logic        exp_neg  = 1'b0;
      logic        hold     = 1'b0;
      logic        exp_ready;
      logic        fin;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (!hold) begin
          zif.z_valid = ($urandom_range(0, 2) != 0);
          if ($urandom_range(0, 3) != 0)
            zif.ctrl = 12'(1) << $urandom_range(0, 11);
          else
            zif.ctrl = 12'($urandom);
          zif.ZHI = $urandom;
          zif.ZLO = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        end
        zif.bus_grant = ($urandom_range(0, 3) != 0);
        settle();

        chk("rnd.wb_done", 32'(zif.wb_done), 32'(exp_done));
        chk("rnd.illegal", 32'(zif.illegal_op), 32'(exp_ill));
`ifdef Z_FLAGS_EN
        chk("rnd.z_zero", 32'(zif.z_zero), 32'(exp_zero));
        chk("rnd.z_neg", 32'(zif.z_neg), 32'(exp_neg));
`endif
        exp_ready = (q.size() == 0) || (q.size() == 1 && zif.bus_grant);
        chk("rnd.z_ready", 32'(zif.z_ready), 32'(exp_ready));
        chk("rnd.bus_req", 32'(zif.bus_req), 32'(q.size() > 0));
        if (q.size() > 0) begin
          chk("rnd.bus_data", zif.bus_data, q[0].data);
          strobes("rnd", zif.bus_grant && q[0].kind == 0,
                  zif.bus_grant && q[0].kind == 1,
                  zif.bus_grant && q[0].kind == 2);
        end else begin
          strobes("rnd.idle", 1'b0, 1'b0, 1'b0);
        end

        fin = 1'b0;
        if (q.size() > 0 && zif.bus_grant) begin
          fin = (q[0].kind != 1);
          void'(q.pop_front());
        end
        if (zif.z_valid && exp_ready) begin
          if (zif.ctrl[8] || zif.ctrl[9]) begin
            q.push_back('{1, zif.ZLO});
            q.push_back('{2, zif.ZHI});
          end else begin
            q.push_back('{0, zif.ZLO});
          end
          if ($countones(zif.ctrl) != 1) exp_ill = 1'b1;
          exp_zero = (zif.ZLO == 32'd0);
          exp_neg  = zif.ZLO[31];
        end
        hold = zif.z_valid && !exp_ready;
        tick();
        exp_done = fin;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
